// File: rtl/gobang_move_ctrl_if.sv
// Button pulses in, board/cursor/game-status outputs back out for the gobang sequencer.
// master drives the buttons (board front-end or bench); slave is the sequencer itself.
interface gobang_move_ctrl_if #(
  parameter int BOARD_N = 15
);
  localparam int NCELL = BOARD_N * BOARD_N;
  localparam int CW    = $clog2(BOARD_N);

  // Buttons are single-cycle pulses with no handshake: a pulse is acted on only if the
  // sequencer is able to take it that cycle (IDLE), otherwise it is dropped, never queued.
  // btn_restart is the exception and is taken in every state.
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_place;
  logic             btn_restart;
  logic [NCELL-1:0] display_black;
  logic [NCELL-1:0] display_white;
  logic [CW-1:0]    choose_row;
  logic [CW-1:0]    choose_col;
  logic [1:0]       who_win;
  logic             turn;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, btn_restart,
    input  display_black, display_white, choose_row, choose_col, who_win, turn, busy,
           dbg_state
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, btn_restart,
    output display_black, display_white, choose_row, choose_col, who_win, turn, busy,
           dbg_state
  );
endinterface

// File: rtl/gobang_move_ctrl.sv
// Gobang game sequencer: cursor movement, alternating stone placement and a one-probe-per-cycle
// five-in-a-row scan around the newly placed stone. All outputs come straight from registers.
module gobang_move_ctrl #(
  parameter int BOARD_N     = 15,
  parameter int WIN_LEN     = 5,
  parameter int CURSOR_WRAP = 1
) (
  input logic             clk,
  input logic             rst,
  gobang_move_ctrl_if.slave bus
);
  localparam int NCELL = BOARD_N * BOARD_N;
  localparam int CW    = $clog2(BOARD_N);
  localparam int IW    = $clog2(NCELL);
  localparam int KW    = $clog2(WIN_LEN + 1);
  localparam int SW    = CW + 2;
  localparam logic [CW-1:0]        MID   = CW'(BOARD_N / 2);
  localparam logic [CW-1:0]        LAST  = CW'(BOARD_N - 1);
  localparam logic signed [SW-1:0] N_S   = SW'(BOARD_N);
  localparam logic [KW-1:0]        K_MAX = KW'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, PLACE, SCAN, DONE} state_t;

  state_t           state, state_next;
  logic [NCELL-1:0] black, white, mover;
  logic [CW-1:0]    row, col, pr, pc;
  logic [1:0]       who_win, d;
  logic             turn, busy, side;
  logic [KW-1:0]    k, count;

  logic signed [SW-1:0] step, probe_r, probe_c;
  logic [IW-1:0]        probe_idx, cursor_idx, place_idx;
  logic                 in_range, hit, win, side_end, last_side, occupied, full;

  // Probe datapath; side=1 is the minus side, so the step is negated rather than the delta.
  always_comb begin
    step    = side ? -SW'(k) : SW'(k);
    probe_r = (d == 2'd0) ? SW'(pr) : SW'(pr) + step;
    case (d)
      2'd1:    probe_c = SW'(pc);
      2'd3:    probe_c = SW'(pc) - step;
      default: probe_c = SW'(pc) + step;
    endcase
    in_range   = !probe_r[SW-1] && (probe_r < N_S) && !probe_c[SW-1] && (probe_c < N_S);
    // Off-board probes never form an index, so edge stones cannot alias into the next row.
    probe_idx  = in_range ? IW'(probe_r[CW-1:0]) * IW'(BOARD_N) + IW'(probe_c[CW-1:0]) : '0;
    mover      = turn ? white : black;
    hit        = in_range && mover[probe_idx];
    win        = hit && (count == K_MAX);
    side_end   = !hit || (k == K_MAX);
    last_side  = side_end && side && (d == 2'd3);
    cursor_idx = IW'(row) * IW'(BOARD_N) + IW'(col);
    place_idx  = IW'(pr) * IW'(BOARD_N) + IW'(pc);
    occupied   = black[cursor_idx] | white[cursor_idx];
    full       = &(black | white);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.btn_place && !occupied) state_next = PLACE;
      PLACE:   state_next = SCAN;
      SCAN: begin
        if (win)            state_next = DONE;
        else if (last_side) state_next = full ? DONE : IDLE;
      end
      default: state_next = DONE;
    endcase
    if (bus.btn_restart) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      black <= '0; white <= '0; row <= MID; col <= MID; who_win <= 2'd0; turn <= 1'b0;
      busy <= 1'b0; pr <= '0; pc <= '0; d <= 2'd0; side <= 1'b0; k <= KW'(1); count <= KW'(1);
    end else if (bus.btn_restart) begin
      black <= '0; white <= '0; row <= MID; col <= MID; who_win <= 2'd0; turn <= 1'b0;
      busy <= 1'b0; pr <= '0; pc <= '0; d <= 2'd0; side <= 1'b0; k <= KW'(1); count <= KW'(1);
    end else begin
      busy <= (state_next == PLACE) || (state_next == SCAN);
      case (state)
        IDLE: begin
          // A place pulse takes priority even when the cell is occupied and ignored.
          if (bus.btn_place) begin
            if (!occupied) begin
              pr <= row;
              pc <= col;
            end
          end else if (bus.btn_up) begin
            if (row == '0) row <= (CURSOR_WRAP != 0) ? LAST : '0;
            else           row <= row - CW'(1);
          end else if (bus.btn_down) begin
            if (row == LAST) row <= (CURSOR_WRAP != 0) ? '0 : LAST;
            else             row <= row + CW'(1);
          end else if (bus.btn_left) begin
            if (col == '0) col <= (CURSOR_WRAP != 0) ? LAST : '0;
            else           col <= col - CW'(1);
          end else if (bus.btn_right) begin
            if (col == LAST) col <= (CURSOR_WRAP != 0) ? '0 : LAST;
            else             col <= col + CW'(1);
          end
        end
        PLACE: begin
          if (turn) white[place_idx] <= 1'b1;
          else      black[place_idx] <= 1'b1;
          d     <= 2'd0;
          side  <= 1'b0;
          k     <= KW'(1);
          count <= KW'(1);
        end
        SCAN: begin
          if (hit) count <= count + KW'(1);
          if (win) who_win <= turn ? 2'd2 : 2'd1;
          if (side_end) begin
            k <= KW'(1);
            if (side) begin
              side  <= 1'b0;
              d     <= d + 2'd1;
              count <= KW'(1);
            end else begin
              side <= 1'b1;
            end
          end else begin
            k <= k + KW'(1);
          end
          if (last_side && !win) begin
            if (full) who_win <= 2'd3;
            else      turn    <= ~turn;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.display_black = black;
  assign bus.display_white = white;
  assign bus.choose_row    = row;
  assign bus.choose_col    = col;
  assign bus.who_win       = who_win;
  assign bus.turn          = turn;
  assign bus.busy          = busy;
  assign bus.dbg_state     = state;
endmodule
